mem_arbiter: RTL and testbench

Two-port scheduler for the 32×16 unified instruction/data memory. It shares the single memory port between the instruction-fetch requester (`if_`) and the load/store requester (`ls_`, including LM/SM multi-word bursts). It drives the memory's active-low read/write strobes, address and write data, and returns read data with per-beat valid strobes. It sits between the multicycle control FSM and the memory block.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_rr.sv | 45 ++++
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: widths, FSM states,
// port identifiers and the wrapping address increment.
package mem_arb_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int MAX_LEN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam logic [MAX_LEN_W-1:0] LEN_ZERO = {MAX_LEN_W{1'b0}};
  localparam logic [MAX_LEN_W-1:0] LEN_ONE  = {{(MAX_LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};

  // Next word address; the natural ADDR_W-bit overflow gives the 31 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr);
    return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin picker. The pointer remembers the last winner
// so that on a tie the other port is chosen; it only moves on a grant.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_ls,
  input  logic en,
  output logic valid,
  output logic winner
);

  logic last_r;

  // Choose the winner from the live requests and the last-winner pointer.
  always_comb begin
    valid  = req_if | req_ls;
    winner = PORT_IF;
    if (req_if && req_ls) begin
      if (last_r == PORT_IF) begin
        winner = PORT_LS;
      end else begin
        winner = PORT_IF;
      end
    end else if (req_ls) begin
      winner = PORT_LS;
    end else begin
      winner = PORT_IF;
    end
  end

  // Pointer register; reset to PORT_LS so that PORT_IF wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= PORT_LS;
    end else if (en) begin
      last_r <= winner;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Scheduler for the single port of the 32x16 unified memory. Arbitrates
// between instruction fetch and load/store, runs one burst at a time
// (one beat per cycle), drives active-low strobes and returns read beats.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 proc_rst,
  input  logic                 if_req,
  input  logic                 if_we,
  input  logic [ADDR_W-1:0]    if_addr,
  input  logic [MAX_LEN_W-1:0] if_len,
  input  logic [DATA_W-1:0]    if_wdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [MAX_LEN_W-1:0] ls_len,
  input  logic [DATA_W-1:0]    ls_wdata,
  output logic                 if_gnt,
  output logic                 if_wnext,
  output logic                 if_rvalid,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_done,
  output logic                 ls_gnt,
  output logic                 ls_wnext,
  output logic                 ls_rvalid,
  output logic [DATA_W-1:0]    ls_rdata,
  output logic                 ls_done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_in,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [DATA_W-1:0]    mem_out
);

  arb_state_e           state_r;
  arb_state_e           state_s;
  logic                 owner_r;
  logic                 we_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [MAX_LEN_W-1:0] cnt_r;

  logic                 arb_valid_s;
  logic                 arb_winner_s;
  logic                 grant_s;
  logic                 last_beat_s;
  logic                 sel_we_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [MAX_LEN_W-1:0] sel_len_s;
  logic [DATA_W-1:0]    sel_wdata_s;
  logic [DATA_W-1:0]    own_wdata_s;
  logic                 read_beat_s;

  assign grant_s     = (state_r == ST_IDLE) && arb_valid_s;
  assign last_beat_s = (cnt_r == LEN_ZERO);
  assign read_beat_s = (mem_read == 1'b0);

  mem_arb_rr u_rr (
    .clk    (clk),
    .rst    (proc_rst),
    .req_if (if_req),
    .req_ls (ls_req),
    .en     (grant_s),
    .valid  (arb_valid_s),
    .winner (arb_winner_s)
  );

  // Attributes of the request that wins arbitration this cycle.
  always_comb begin
    sel_we_s    = if_we;
    sel_addr_s  = if_addr;
    sel_len_s   = if_len;
    sel_wdata_s = if_wdata;
    if (arb_winner_s == PORT_LS) begin
      sel_we_s    = ls_we;
      sel_addr_s  = ls_addr;
      sel_len_s   = ls_len;
      sel_wdata_s = ls_wdata;
    end else begin
      sel_we_s    = if_we;
      sel_addr_s  = if_addr;
      sel_len_s   = if_len;
      sel_wdata_s = if_wdata;
    end
  end

  // Write data of the port that owns the running burst.
  always_comb begin
    own_wdata_s = if_wdata;
    if (owner_r == PORT_LS) begin
      own_wdata_s = ls_wdata;
    end else begin
      own_wdata_s = if_wdata;
    end
  end

  // Next state, grant pulses and the write-data advance handshake.
  always_comb begin
    state_s  = state_r;
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    if_wnext = 1'b0;
    ls_wnext = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_s = ST_BURST;
          if (arb_winner_s == PORT_LS) begin
            ls_gnt   = 1'b1;
            ls_wnext = sel_we_s;
          end else begin
            if_gnt   = 1'b1;
            if_wnext = sel_we_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (last_beat_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BURST;
          if (owner_r == PORT_LS) begin
            ls_wnext = we_r;
          end else begin
            if_wnext = we_r;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst bookkeeping and registered memory address/data/strobes.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      owner_r   <= PORT_IF;
      we_r      <= 1'b0;
      addr_r    <= ADDR_ZERO;
      cnt_r     <= LEN_ZERO;
      mem_addr  <= ADDR_ZERO;
      mem_in    <= DATA_ZERO;
      mem_read  <= 1'b1;
      mem_write <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            owner_r   <= arb_winner_s;
            we_r      <= sel_we_s;
            cnt_r     <= sel_len_s;
            addr_r    <= addr_inc(sel_addr_s);
            mem_addr  <= sel_addr_s;
            mem_read  <= sel_we_s;
            mem_write <= ~sel_we_s;
            if (sel_we_s) begin
              mem_in <= sel_wdata_s;
            end
          end else begin
            mem_read  <= 1'b1;
            mem_write <= 1'b1;
          end
        end
        ST_BURST: begin
          if (!last_beat_s) begin
            cnt_r     <= cnt_r - LEN_ONE;
            addr_r    <= addr_inc(addr_r);
            mem_addr  <= addr_r;
            mem_read  <= we_r;
            mem_write <= ~we_r;
            if (we_r) begin
              mem_in <= own_wdata_s;
            end
          end else begin
            mem_read  <= 1'b1;
            mem_write <= 1'b1;
          end
        end
        default: begin
          mem_read  <= 1'b1;
          mem_write <= 1'b1;
        end
      endcase
    end
  end

  // Read-beat capture into the owner's rdata and burst completion pulses.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= DATA_ZERO;
      ls_rdata  <= DATA_ZERO;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
    end else begin
      if_rvalid <= read_beat_s && (owner_r == PORT_IF);
      ls_rvalid <= read_beat_s && (owner_r == PORT_LS);
      if (read_beat_s && (owner_r == PORT_IF)) begin
        if_rdata <= mem_out;
      end
      if (read_beat_s && (owner_r == PORT_LS)) begin
        ls_rdata <= mem_out;
      end
      if_done <= (state_r == ST_BURST) && last_beat_s && (owner_r == PORT_IF);
      ls_done <= (state_r == ST_BURST) && last_beat_s && (owner_r == PORT_LS);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model of the
// scheduler plus a 32x16 memory with falling-edge read/write behaviour.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic                 clk = 1'b0;
  logic                 proc_rst;
  logic                 if_req, if_we, ls_req, ls_we;
  logic [ADDR_W-1:0]    if_addr, ls_addr;
  logic [MAX_LEN_W-1:0] if_len, ls_len;
  logic [DATA_W-1:0]    if_wdata, ls_wdata;
  logic                 if_gnt, if_wnext, if_rvalid, if_done;
  logic                 ls_gnt, ls_wnext, ls_rvalid, ls_done;
  logic [DATA_W-1:0]    if_rdata, ls_rdata;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_in;
  logic                 mem_write, mem_read;
  logic [DATA_W-1:0]    mem_out = 16'd0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .proc_rst(proc_rst),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_len(if_len), .if_wdata(if_wdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
    .if_gnt(if_gnt), .if_wnext(if_wnext), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
    .ls_gnt(ls_gnt), .ls_wnext(ls_wnext), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_write(mem_write), .mem_read(mem_read), .mem_out(mem_out)
  );

  // Memory model driven by the DUT strobes: acts on the falling edge.
  logic [DATA_W-1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'(i) - 16'd1;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b0) mem[mem_addr] = mem_in;
      if (mem_read === 1'b0) mem_out = mem[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state (one burst record, last winner, memory image).
  bit m_busy;
  int m_start, m_owner, m_addr, m_len, m_last;
  bit m_we;
  logic [DATA_W-1:0] ref_mem [32];

  // Requester state per port (0 = if_, 1 = ls_).
  bit pend [2];
  bit rq_we [2];
  int rq_addr [2];
  int rq_len [2];
  logic [DATA_W-1:0] rq_data [2][8];
  int widx [2];
  bit auto_req [2];
  bit rnd_mode;
  bit do_rst;

  // Observation logs for the directed literal checks.
  int q_gnt [$];
  logic [DATA_W-1:0] q_if_rd [$];
  logic [DATA_W-1:0] q_ls_rd [$];
  int q_wr_addr [$];
  logic [DATA_W-1:0] q_wr_data [$];
  int gnt_cyc [2];
  int done_cyc [2];
  int rv_cyc [2];
  int n_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic issue(input int p, input bit we, input int addr, input int len,
                       input logic [DATA_W-1:0] base);
    rq_we[p]   = we;
    rq_addr[p] = addr;
    rq_len[p]  = len;
    for (int i = 0; i < 8; i++) rq_data[p][i] = base + 16'(i);
    widx[p] = 0;
    pend[p] = 1'b1;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step();
    int k, j, win, e_addr;
    bit e_gnt [2], e_wn [2], e_rv [2], e_dn [2];
    bit e_rd, e_wr, beat;
    logic [DATA_W-1:0] e_din, e_rdata;

    for (int p = 0; p < 2; p++) begin
      if (rnd_mode && pend[p] && $urandom_range(0, 31) == 0) pend[p] = 1'b0;
      if (!pend[p] && !(m_busy && m_owner == p)) begin
        if (auto_req[p]) issue(p, 1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), 16'd0);
        else if (rnd_mode && $urandom_range(0, 3) == 0)
          issue(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 7)), 16'($urandom));
      end
    end
    proc_rst = do_rst;
    if_req = pend[0]; if_we = rq_we[0]; if_addr = 5'(rq_addr[0]); if_len = 3'(rq_len[0]);
    if_wdata = rq_data[0][widx[0]];
    ls_req = pend[1]; ls_we = rq_we[1]; ls_addr = 5'(rq_addr[1]); ls_len = 3'(rq_len[1]);
    ls_wdata = rq_data[1][widx[1]];

    @(negedge clk);
    win = -1; k = 0; e_addr = 0; beat = 1'b0; e_rd = 1'b1; e_wr = 1'b1;
    e_din = 16'd0; e_rdata = 16'd0;
    for (int p = 0; p < 2; p++) begin
      e_gnt[p] = 1'b0; e_wn[p] = 1'b0; e_rv[p] = 1'b0; e_dn[p] = 1'b0;
    end
    if (!m_busy) begin
      if (pend[0] && pend[1]) win = (m_last == 0) ? 1 : 0;
      else if (pend[0]) win = 0;
      else if (pend[1]) win = 1;
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        e_wn[win]  = rq_we[win];
      end
    end else begin
      k = cyc - m_start;
      if (k >= 1 && k <= m_len + 1) begin
        j = k - 1;
        beat = 1'b1;
        e_addr = (m_addr + j) % 32;
        if (m_we) begin
          e_wr = 1'b0;
          e_din = rq_data[m_owner][j];
          e_wn[m_owner] = (k <= m_len);
        end else begin
          e_rd = 1'b0;
        end
      end
      if (!m_we && k >= 2 && k <= m_len + 2) begin
        e_rv[m_owner] = 1'b1;
        e_rdata = ref_mem[(m_addr + k - 2) % 32];
      end
      if (k == m_len + 2) e_dn[m_owner] = 1'b1;
    end

    chk("if_gnt", 32'(if_gnt), 32'(e_gnt[0]));
    chk("ls_gnt", 32'(ls_gnt), 32'(e_gnt[1]));
    chk("if_wnext", 32'(if_wnext), 32'(e_wn[0]));
    chk("ls_wnext", 32'(ls_wnext), 32'(e_wn[1]));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_rv[0]));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_rv[1]));
    chk("if_done", 32'(if_done), 32'(e_dn[0]));
    chk("ls_done", 32'(ls_done), 32'(e_dn[1]));
    chk("mem_read", 32'(mem_read), 32'(e_rd));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("strobe_excl", 32'(mem_read === 1'b0 && mem_write === 1'b0), 32'd0);
    if (beat) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (beat && m_we) chk("mem_in", 32'(mem_in), 32'(e_din));
    if (e_rv[0]) chk("if_rdata", 32'(if_rdata), 32'(e_rdata));
    if (e_rv[1]) chk("ls_rdata", 32'(ls_rdata), 32'(e_rdata));

    if (if_gnt) begin q_gnt.push_back(0); gnt_cyc[0] = cyc; end
    if (ls_gnt) begin q_gnt.push_back(1); gnt_cyc[1] = cyc; end
    if (if_rvalid) begin q_if_rd.push_back(if_rdata); rv_cyc[0] = cyc; end
    if (ls_rvalid) begin q_ls_rd.push_back(ls_rdata); rv_cyc[1] = cyc; end
    if (if_done) begin done_cyc[0] = cyc; n_done[0]++; end
    if (ls_done) begin done_cyc[1] = cyc; n_done[1]++; end
    if (mem_write === 1'b0) begin q_wr_addr.push_back(int'(mem_addr)); q_wr_data.push_back(mem_in); end

    if (beat && m_we) ref_mem[e_addr] = e_din;
    for (int p = 0; p < 2; p++) if (e_wn[p] && widx[p] < 7) widx[p]++;
    if (do_rst) begin
      m_busy = 1'b0;
      m_last = 1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1'b1; m_start = cyc; m_owner = win; m_we = rq_we[win];
        m_addr = rq_addr[win]; m_len = rq_len[win]; m_last = win; pend[win] = 1'b0;
      end
    end else if (k == m_len + 2) begin
      m_busy = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int limit);
    int n = 0;
    while ((pend[0] || pend[1] || m_busy) && n < limit) begin
      step();
      n++;
    end
    if (pend[0] || pend[1] || m_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_idle cycle %0d: still busy after %0d cycles", cyc, limit);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'(i) - 16'd1;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = 0; rq_len[p] = 0; widx[p] = 0;
      auto_req[p] = 1'b0; n_done[p] = 0; gnt_cyc[p] = 0; done_cyc[p] = 0; rv_cyc[p] = 0;
      for (int i = 0; i < 8; i++) rq_data[p][i] = 16'd0;
    end
    m_busy = 1'b0; m_last = 1; m_start = 0; m_owner = 0; m_addr = 0; m_len = 0; m_we = 1'b0;
    rnd_mode = 1'b0; do_rst = 1'b0;
    proc_rst = 1'b1;
    if_req = 1'b0; if_we = 1'b0; if_addr = 5'd0; if_len = 3'd0; if_wdata = 16'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 5'd0; ls_len = 3'd0; ls_wdata = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_in", 32'(mem_in), 32'd0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 32'd0);
    chk("rst_pulses", 32'({if_gnt, ls_gnt, if_wnext, ls_wnext, if_rvalid, ls_rvalid, if_done, ls_done}), 32'd0);
    @(posedge clk);
    #1;

    // Single read: if_, addr 2, len 0 -> data 1, rvalid and done two cycles after gnt.
    issue(0, 1'b0, 2, 0, 16'd0);
    run_idle(40);
    chk("single_rd_count", 32'(q_if_rd.size()), 32'd1);
    if (q_if_rd.size() >= 1) chk("single_rd_data", 32'(q_if_rd[0]), 32'd1);
    chk("single_rd_done_lat", 32'(done_cyc[0] - gnt_cyc[0]), 32'd2);
    chk("single_rd_rv_lat", 32'(rv_cyc[0] - gnt_cyc[0]), 32'd2);

    // LM-style burst: ls_, addr 2, len 7 -> data 1..8, done with the last beat.
    q_ls_rd.delete();
    issue(1, 1'b0, 2, 7, 16'd0);
    run_idle(40);
    chk("lm_count", 32'(q_ls_rd.size()), 32'd8);
    for (int i = 0; i < 8 && i < q_ls_rd.size(); i++) chk("lm_data", 32'(q_ls_rd[i]), 32'(i + 1));
    chk("lm_done_lat", 32'(done_cyc[1] - gnt_cyc[1]), 32'd9);
    chk("lm_last_rv_done", 32'(rv_cyc[1]), 32'(done_cyc[1]));

    // SM write with wrap: addr 30, len 3, data A0..A3, then read back.
    q_wr_addr.delete(); q_wr_data.delete();
    issue(1, 1'b1, 30, 3, 16'h00A0);
    run_idle(40);
    chk("sm_count", 32'(q_wr_addr.size()), 32'd4);
    if (q_wr_addr.size() == 4) begin
      chk("sm_addr0", 32'(q_wr_addr[0]), 32'd30);
      chk("sm_addr1", 32'(q_wr_addr[1]), 32'd31);
      chk("sm_addr2", 32'(q_wr_addr[2]), 32'd0);
      chk("sm_addr3", 32'(q_wr_addr[3]), 32'd1);
      for (int i = 0; i < 4; i++) chk("sm_data", 32'(q_wr_data[i]), 32'h000000A0 + 32'(i));
    end
    q_ls_rd.delete();
    issue(1, 1'b0, 30, 3, 16'd0);
    run_idle(40);
    chk("sm_rb_count", 32'(q_ls_rd.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_ls_rd.size(); i++) chk("sm_rb_data", 32'(q_ls_rd[i]), 32'h000000A0 + 32'(i));

    // Contention from reset: grants alternate starting with if_.
    do_rst = 1'b1; step(); do_rst = 1'b0;
    q_gnt.delete();
    auto_req[0] = 1'b1; auto_req[1] = 1'b1;
    repeat (40) step();
    auto_req[0] = 1'b0; auto_req[1] = 1'b0;
    run_idle(40);
    chk("rr_grants", 32'(q_gnt.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < q_gnt.size(); i++) chk("rr_order", 32'(q_gnt[i]), 32'(i % 2));

    // Reset in the third beat of a len-7 read, then a normal if_ request.
    issue(0, 1'b0, 0, 7, 16'd0);
    n = 0;
    while (!(m_busy && (cyc - m_start) == 3) && n < 20) begin step(); n++; end
    chk("rst_mid_reached", 32'(m_busy && (cyc - m_start) == 3), 32'd1);
    n = n_done[0];
    do_rst = 1'b1; step(); do_rst = 1'b0;
    chk("rst_mid_strobes", 32'({mem_read, mem_write}), 32'd3);
    chk("rst_mid_rvalid", 32'(if_rvalid), 32'd0);
    repeat (4) step();
    chk("rst_mid_no_done", 32'(n_done[0] - n), 32'd0);
    q_if_rd.delete(); q_gnt.delete();
    issue(0, 1'b0, 4, 0, 16'd0);
    run_idle(40);
    chk("rst_mid_regrant", 32'(q_gnt.size()), 32'd1);
    if (q_if_rd.size() >= 1) chk("rst_mid_rd_data", 32'(q_if_rd[0]), 32'd3);
    else chk("rst_mid_rd_count", 32'(q_if_rd.size()), 32'd1);

    // Random mixed traffic.
    rnd_mode = 1'b1;
    repeat (10000) step();
    rnd_mode = 1'b0;
    run_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
